// File: rtl/alu_pkg.sv
// Shared definitions for the Simple ALU execute stage: opcodes, FSM states,
// flag bit positions and small opcode-classification helpers.
package alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_NOT = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERIAL = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Bit positions inside the packed flag vector seen by the downstream flag register
    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_ERR   = 2;
    localparam int FLAG_W     = 3;

    function automatic logic is_arith(input logic [2:0] code);
        return (code == OP_ADD) || (code == OP_SUB);
    endfunction

    function automatic logic is_illegal(input logic [2:0] code);
        return code[2] & code[1];
    endfunction

endpackage

// File: rtl/alu_fa_bit.sv
// One-bit full adder slice; the serial ADD/SUB path reuses a single instance
// of it once per bit.
module alu_fa_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/alu_serial_exec.sv
// Sequenced ALU execute stage: single-cycle bitwise ops, bit-serial ADD/SUB
// through one full-adder slice, registered result and flags held until taken.
module alu_serial_exec
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_zero,
    output logic             flag_carry,
    output logic             flag_err
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             last_bit;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_next;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] logic_res;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q;
    logic [FLAG_W-1:0] flags_q;

    logic             fa_s;
    logic             fa_cout;

    alu_fa_bit u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    assign last_bit = (cnt_q == LAST_BIT);
    assign sum_next = {fa_s, sum_q[WIDTH-1:1]};

    // Bitwise ops are evaluated on the request as it is accepted so the result
    // can be registered on the accepting edge.
    always_comb begin
        logic_res = '0;
        case (op)
            OP_AND:  logic_res = a & b;
            OP_OR:   logic_res = a | b;
            OP_XOR:  logic_res = a ^ b;
            OP_NOT:  logic_res = ~a;
            default: logic_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = is_arith(op) ? SERIAL : DONE;
                end
            end
            SERIAL: begin
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operands shift right so the adder always sees bit 0; sums enter at the
    // MSB of a scratch register so the visible result only changes on completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            sum_q    <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= (op == OP_SUB) ? ~b : b;
            carry_q <= (op == OP_SUB);
            sum_q   <= '0;
            cnt_q   <= '0;
            if (!is_arith(op)) begin
                result_q            <= logic_res;
                flags_q[FLAG_ZERO]  <= (logic_res == '0);
                flags_q[FLAG_CARRY] <= 1'b0;
                flags_q[FLAG_ERR]   <= is_illegal(op);
            end
        end else if (state == SERIAL) begin
            a_q     <= a_q >> 1;
            b_q     <= b_q >> 1;
            carry_q <= fa_cout;
            sum_q   <= sum_next;
            cnt_q   <= cnt_q + CNT_W'(1);
            if (last_bit) begin
                result_q            <= sum_next;
                flags_q[FLAG_ZERO]  <= (sum_next == '0);
                flags_q[FLAG_CARRY] <= fa_cout;
                flags_q[FLAG_ERR]   <= 1'b0;
            end
        end
    end

    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);
    assign result     = result_q;
    assign flag_zero  = flags_q[FLAG_ZERO];
    assign flag_carry = flags_q[FLAG_CARRY];
    assign flag_err   = flags_q[FLAG_ERR];

endmodule

// File: tb/tb_alu_serial_exec.sv
// Self-checking bench for alu_serial_exec: directed scenarios followed by
// randomized transactions checked against an arithmetic reference model.
module tb_alu_serial_exec;

    localparam int WIDTH = 4;
    localparam int WAIT_LIMIT = 3 * WIDTH + 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag_zero;
    logic             flag_carry;
    logic             flag_err;

    int vectors;
    int miscompares;

    alu_serial_exec #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .flag_zero  (flag_zero),
        .flag_carry (flag_carry),
        .flag_err   (flag_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: {err, carry, zero, result} from plain integer arithmetic.
    function automatic logic [WIDTH+2:0] model(input logic [2:0] o,
                                               input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
        int ix = int'(x);
        int iy = int'(y);
        int modulus = 1 << WIDTH;
        int r = 0;
        logic c = 1'b0;
        logic e = 1'b0;
        case (o)
            3'd0: r = int'(x & y);
            3'd1: r = int'(x | y);
            3'd2: r = int'(x ^ y);
            3'd3: r = int'(~x);
            3'd4: begin
                r = (ix + iy) % modulus;
                c = (ix + iy) >= modulus;
            end
            3'd5: begin
                r = (ix - iy + modulus) % modulus;
                c = ix >= iy;
            end
            default: e = 1'b1;
        endcase
        return {e, c, (r == 0), WIDTH'(r)};
    endfunction

    function automatic int latency(input logic [2:0] o);
        return (o == 3'd4 || o == 3'd5) ? WIDTH + 1 : 1;
    endfunction

    // Presents one request for a single cycle, then scrambles the inputs.
    task automatic applyStimulus(input logic [2:0] o, input logic [WIDTH-1:0] x,
                                 input logic [WIDTH-1:0] y);
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        op = o;
        a = x;
        b = y;
        tick();
        in_valid = 1'b0;
        op = 3'($urandom);
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
    endtask

    task automatic waitOutput(input logic [2:0] o);
        int lat = 1;
        while (!out_valid && lat < WAIT_LIMIT) begin
            check("in_ready_busy", 32'(in_ready), 32'd0);
            tick();
            lat++;
        end
        check("out_valid_timeout", 32'(out_valid), 32'd1);
        check("latency", 32'(lat), 32'(latency(o)));
    endtask

    task automatic checkOutput(input string tag, input logic [2:0] o,
                               input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        logic [WIDTH+2:0] exp = model(o, x, y);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_result"}, 32'(result), 32'(exp[WIDTH-1:0]));
        check({tag, "_zero"}, 32'(flag_zero), 32'(exp[WIDTH]));
        check({tag, "_carry"}, 32'(flag_carry), 32'(exp[WIDTH+1]));
        check({tag, "_err"}, 32'(flag_err), 32'(exp[WIDTH+2]));
        check({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
    endtask

    task automatic releaseOutput();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("out_valid_after_take", 32'(out_valid), 32'd0);
        check("in_ready_after_take", 32'(in_ready), 32'd1);
    endtask

    task automatic runTxn(input string tag, input logic [2:0] o,
                          input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        applyStimulus(o, x, y);
        waitOutput(o);
        checkOutput(tag, o, x, y);
        releaseOutput();
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        op = '0;
        a = '0;
        b = '0;
        tick();
        tick();
        rst = 1'b0;

        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_result", 32'(result), 32'd0);
        check("reset_flags", {29'd0, flag_err, flag_carry, flag_zero}, 32'd0);

        runTxn("and", 3'd0, 4'b1100, 4'b1010);

        out_ready = 1'b1;
        applyStimulus(3'd4, 4'b1001, 4'b1000);
        out_ready = 1'b1;
        waitOutput(3'd4);
        checkOutput("add", 3'd4, 4'b1001, 4'b1000);
        releaseOutput();

        runTxn("sub_eq", 3'd5, 4'b0011, 4'b0011);
        runTxn("sub_borrow", 3'd5, 4'b0010, 4'b0101);

        applyStimulus(3'd2, 4'b0110, 4'b0110);
        waitOutput(3'd2);
        for (int i = 0; i < 3; i++) begin
            checkOutput("xor_hold", 3'd2, 4'b0110, 4'b0110);
            if (i == 1) begin
                in_valid = 1'b1;
                op = 3'd1;
                a = 4'b1111;
                b = 4'b1111;
            end
            tick();
            in_valid = 1'b0;
        end
        checkOutput("xor_held", 3'd2, 4'b0110, 4'b0110);
        releaseOutput();
        check("no_queued_request", 32'(out_valid), 32'd0);

        runTxn("illegal", 3'd6, 4'b1111, 4'b0000);
        runTxn("after_illegal", 3'd0, 4'b1111, 4'b0011);

        applyStimulus(3'd4, 4'b0111, 4'b0001);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_result", 32'(result), 32'd0);
        check("abort_flags", {29'd0, flag_err, flag_carry, flag_zero}, 32'd0);
        runTxn("or_after_abort", 3'd1, 4'b0101, 4'b0010);

        for (int n = 0; n < 40; n++) begin
            logic [2:0]       ro = 3'($urandom_range(0, 7));
            logic [WIDTH-1:0] ra = WIDTH'($urandom);
            logic [WIDTH-1:0] rb = WIDTH'($urandom);
            int               hold = $urandom_range(0, 2);
            applyStimulus(ro, ra, rb);
            waitOutput(ro);
            for (int h = 0; h < hold; h++) begin
                tick();
            end
            checkOutput("random", ro, ra, rb);
            releaseOutput();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
